// File: rtl/traffic_input_conditioner.sv
// Input front end for the traffic light controller: one-second advance tick,
// synchronized/debounced car sensor and walk button, and a sticky walk request.
module traffic_input_conditioner #(
    parameter int CLK_DIV   = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_raw,
    input  logic walk_raw,
    input  logic walk_ack,
    output logic sec_tick,
    output logic sensor,
    output logic walk_press,
    output logic walk_req
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DB_CYCLES) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    logic          sensor_s1_q, sensor_s1_d;
    logic          sensor_s2_q, sensor_s2_d;
    logic          sensor_stable_q, sensor_stable_d;
    logic [DW-1:0] sensor_cnt_q, sensor_cnt_d;

    logic          walk_s1_q, walk_s1_d;
    logic          walk_s2_q, walk_s2_d;
    logic          walk_stable_q, walk_stable_d;
    logic [DW-1:0] walk_cnt_q, walk_cnt_d;
    logic          walk_accept;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          sec_tick_q, sec_tick_d;
    logic          walk_press_q, walk_press_d;
    logic          walk_req_q, walk_req_d;

    // walk_req/walk_ack handshake: walk_req rises with each accepted press and
    // holds until the controller pulses walk_ack; a press landing on the same
    // edge as an ack keeps the request set so it is never lost.
    always_comb begin
        sensor_s1_d     = sensor_raw;
        sensor_s2_d     = sensor_s1_q;
        sensor_stable_d = sensor_stable_q;
        sensor_cnt_d    = sensor_cnt_q;
        walk_s1_d       = walk_raw;
        walk_s2_d       = walk_s1_q;
        walk_stable_d   = walk_stable_q;
        walk_cnt_d      = walk_cnt_q;
        walk_accept     = 1'b0;
        tick_cnt_d      = tick_cnt_q;
        sec_tick_d      = 1'b0;
        walk_press_d    = 1'b0;
        walk_req_d      = walk_req_q;

        // Any return to the stable level restarts the qualification count.
        if (sensor_s2_q == sensor_stable_q) begin
            sensor_cnt_d = '0;
        end else if (sensor_cnt_q == DB_LAST) begin
            sensor_stable_d = sensor_s2_q;
            sensor_cnt_d    = '0;
        end else begin
            sensor_cnt_d = sensor_cnt_q + DW'(1);
        end

        if (walk_s2_q == walk_stable_q) begin
            walk_cnt_d = '0;
        end else if (walk_cnt_q == DB_LAST) begin
            walk_stable_d = walk_s2_q;
            walk_cnt_d    = '0;
            walk_accept   = 1'b1;
        end else begin
            walk_cnt_d = walk_cnt_q + DW'(1);
        end

        walk_press_d = walk_accept && walk_s2_q;
        if (walk_press_d) begin
            walk_req_d = 1'b1;
        end else if (walk_ack) begin
            walk_req_d = 1'b0;
        end

        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            sec_tick_d = 1'b1;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sensor_s1_q     <= 1'b0;
            sensor_s2_q     <= 1'b0;
            sensor_stable_q <= 1'b0;
            sensor_cnt_q    <= '0;
            walk_s1_q       <= 1'b0;
            walk_s2_q       <= 1'b0;
            walk_stable_q   <= 1'b0;
            walk_cnt_q      <= '0;
            tick_cnt_q      <= '0;
            sec_tick_q      <= 1'b0;
            walk_press_q    <= 1'b0;
            walk_req_q      <= 1'b0;
        end else begin
            sensor_s1_q     <= sensor_s1_d;
            sensor_s2_q     <= sensor_s2_d;
            sensor_stable_q <= sensor_stable_d;
            sensor_cnt_q    <= sensor_cnt_d;
            walk_s1_q       <= walk_s1_d;
            walk_s2_q       <= walk_s2_d;
            walk_stable_q   <= walk_stable_d;
            walk_cnt_q      <= walk_cnt_d;
            tick_cnt_q      <= tick_cnt_d;
            sec_tick_q      <= sec_tick_d;
            walk_press_q    <= walk_press_d;
            walk_req_q      <= walk_req_d;
        end
    end

    assign sec_tick   = sec_tick_q;
    assign sensor     = sensor_stable_q;
    assign walk_press = walk_press_q;
    assign walk_req   = walk_req_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner: the driver pushes the expected
// output vector after every edge and a negedge monitor pops and compares it.
module tb_traffic_input_conditioner;

    localparam int CLK_DIV   = 10;
    localparam int DB_CYCLES = 4;

    logic clk = 1'b0;
    logic rst;
    logic sensor_raw;
    logic walk_raw;
    logic walk_ack;
    logic sec_tick;
    logic sensor;
    logic walk_press;
    logic walk_req;

    traffic_input_conditioner #(
        .CLK_DIV  (CLK_DIV),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_raw(sensor_raw),
        .walk_raw  (walk_raw),
        .walk_ack  (walk_ack),
        .sec_tick  (sec_tick),
        .sensor    (sensor),
        .walk_press(walk_press),
        .walk_req  (walk_req)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {sec_tick, sensor, walk_press, walk_req}
    logic [3:0] exp_q[$];
    int         lbl_q[$];
    int         checks = 0;
    int         passed = 0;
    int         edge_n = 0;
    int         edge_total = 0;
    logic       exp_sensor = 1'b0;
    logic       exp_press = 1'b0;
    logic       exp_req = 1'b0;

    // One clock edge; expected tick comes from the edge count since reset.
    task automatic step();
        logic r;
        logic t;
        r = rst;
        @(posedge clk);
        #1;
        edge_total++;
        if (r) begin
            edge_n     = 0;
            exp_sensor = 1'b0;
            exp_press  = 1'b0;
            exp_req    = 1'b0;
            t          = 1'b0;
        end else begin
            edge_n++;
            t = ((edge_n % CLK_DIV) == 0);
        end
        exp_q.push_back({t, exp_sensor, exp_press, exp_req});
        lbl_q.push_back(edge_total);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            logic [3:0] a;
            int         lbl;
            e   = exp_q.pop_front();
            lbl = lbl_q.pop_front();
            a   = {sec_tick, sensor, walk_press, walk_req};
            checks++;
            if (a === e) passed++;
            else $display("FAIL outputs edge %0d: got tick/sensor/press/req=%b expected %b", lbl, a, e);
        end
    end

    initial begin
        rst        = 1'b1;
        sensor_raw = 1'b0;
        walk_raw   = 1'b0;
        walk_ack   = 1'b0;

        // Reset and tick period, including a reset in the middle of a period
        run(3);
        rst = 1'b0;
        run(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(24);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(12);

        // Clean press: pulse after the 6th edge from the raw change
        walk_raw = 1'b1;
        run(5);
        exp_press = 1'b1;
        exp_req   = 1'b1;
        step();
        exp_press = 1'b0;
        run(14);

        walk_raw = 1'b0;
        run(8);

        walk_ack = 1'b1;
        exp_req  = 1'b0;
        step();
        walk_ack = 1'b0;
        run(2);

        // Ack with no request pending
        walk_ack = 1'b1;
        step();
        walk_ack = 1'b0;
        run(2);

        // Bounce rejection on both inputs
        walk_raw = 1'b1;
        run(2);
        walk_raw = 1'b0;
        run(2);
        walk_raw = 1'b1;
        run(2);
        walk_raw = 1'b0;
        run(10);
        sensor_raw = 1'b1;
        run(3);
        sensor_raw = 1'b0;
        run(10);

        // Ack clears, then a re-press accepted on the same edge as an ack
        walk_raw = 1'b1;
        run(5);
        exp_press = 1'b1;
        exp_req   = 1'b1;
        step();
        exp_press = 1'b0;
        run(3);
        walk_ack = 1'b1;
        exp_req  = 1'b0;
        step();
        walk_ack = 1'b0;
        walk_raw = 1'b0;
        run(8);
        walk_raw = 1'b1;
        run(5);
        walk_ack  = 1'b1;
        exp_press = 1'b1;
        exp_req   = 1'b1;
        step();
        walk_ack  = 1'b0;
        exp_press = 1'b0;
        run(3);

        // Held button: one press over 50 cycles
        walk_raw = 1'b0;
        run(8);
        walk_ack = 1'b1;
        exp_req  = 1'b0;
        step();
        walk_ack = 1'b0;
        walk_raw = 1'b1;
        run(5);
        exp_press = 1'b1;
        exp_req   = 1'b1;
        step();
        exp_press = 1'b0;
        run(44);

        // Reset drops a pending request
        walk_raw = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        run(3);

        // Sensor level 1 -> 0 -> 1, 8 cycles each
        sensor_raw = 1'b1;
        run(5);
        exp_sensor = 1'b1;
        run(3);
        sensor_raw = 1'b0;
        run(5);
        exp_sensor = 1'b0;
        run(3);
        sensor_raw = 1'b1;
        run(5);
        exp_sensor = 1'b1;
        run(3);
        run(6);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/traffic_input_conditioner.md
# traffic_input_conditioner

Front-end stage for the traffic light controller. It generates the one-second advance enable that paces the controller's phase timing, and it cleans up the two raw field inputs: the side-street car sensor and the pedestrian walk button. Each raw input is synchronized and debounced. The walk button is also converted into a sticky request that stays set until the controller acknowledges it. Everything runs on the single system clock, so the controller no longer needs a divided clock.

## Interface
- CLK_DIV, 100000000: clock cycles per `sec_tick` period; must be ≥2.
- DB_CYCLES, 1000000: consecutive cycles an input must hold a new value before it is accepted; must be ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sensor_raw  in  1  asynchronous car-sensor level.
- walk_raw  in  1  asynchronous walk-button level (1 = pressed).
- walk_ack  in  1  one-cycle pulse from the controller; clears `walk_req`.
- sec_tick  out  1  one-cycle advance-enable pulse, once every CLK_DIV cycles.
- sensor  out  1  debounced sensor level.
- walk_press  out  1  one-cycle pulse on each accepted button press.
- walk_req  out  1  sticky pedestrian request.

## Operation
- **Synchronizers.** Each raw input passes through a 2-flop synchronizer (s1 → s2). Only s2 is used downstream.
- **Debouncer state.** There is one debouncer per input. Each holds a `stable` register and a counter of width clog2(DB_CYCLES)+1.
- **Debouncer, no change.** If s2 == stable, the counter is cleared to 0.
- **Debouncer, counting.** If s2 != stable and counter < DB_CYCLES-1, the counter increments.
- **Debouncer, accept.** If s2 != stable and counter == DB_CYCLES-1, stable takes s2 and the counter clears.
- **Bounce handling.** Any return of s2 to the stable value before acceptance restarts the count from 0.
- **sensor output.** `sensor` is the sensor debouncer's `stable` register.
- **walk_press.** It is registered high for one cycle on the edge where the walk debouncer accepts a 0→1 change. Accepting a 1→0 change produces no pulse.
- **walk_req.** It is set on the edge where `walk_press` is generated and cleared on an edge where `walk_ack` = 1.
- **Set/clear collision.** If set and clear happen on the same edge, set wins, so a new press is never lost. `walk_ack` while `walk_req` = 0 has no effect.
- **Tick counter.** It counts 0..CLK_DIV-1 and wraps to 0, with width clog2(CLK_DIV).
- **sec_tick.** It is registered high for exactly the one cycle following the edge at which the counter wraps to 0, and low otherwise. The tick counter free-runs and is unaffected by the inputs or `walk_ack`.

## Timing
- **Reset values.** All outputs, synchronizer flops, `stable` registers and counters are 0 at reset. Reset wins over all other updates on the same edge.
- **Reset mid-operation.** Reset mid-count aborts any pending debounce and restarts the tick period. Reset drops `walk_req` even if a request is pending.
- **Edge numbering.** Edge 1 is the first rising edge with `rst` = 0.
- **sec_tick timing.** `sec_tick` is high during the cycle after edge CLK_DIV, then after edges 2·CLK_DIV, 3·CLK_DIV, and so on. Period is exactly CLK_DIV, duty is 1 cycle.
- **Debounce latency.** Let a raw change meet setup before edge 0 and stay constant. Then s2 shows the new value after edge 1, and `stable` (and `sensor`) changes after edge DB_CYCLES+1.
- **Press latency.** `walk_press` and the `walk_req` rise appear after that same edge DB_CYCLES+1.
- **Short pulses rejected.** A raw pulse shorter than DB_CYCLES cycles (after synchronization) never changes `stable`.
- **Ack latency.** `walk_ack` high at edge n makes `walk_req` = 0 after edge n, unless a set occurs at edge n.
- **Held button.** A button held indefinitely gives exactly one `walk_press`. A new press requires an accepted release first.

## Test plan
Use CLK_DIV=10 and DB_CYCLES=4 for all scenarios.
- **Reset / tick.** Hold rst for 3 cycles, then release with inputs at 0 → all outputs 0. `sec_tick` pulses are seen after edges 10, 20 and 30, each exactly 1 cycle wide. Asserting rst at edge 25 → no pulse at edge 30, and the next pulse comes after edge 35.
- **Clean press.** `walk_raw` rises before edge 0 and is held for 20 cycles → `walk_press` = 1 only after edge 5. `walk_req` = 1 from edge 5 onward.
- **Bounce rejection.** `walk_raw` toggles 1,0,1,0 with 2-cycle high periods, then stays 0 → `walk_press` never fires and `walk_req` stays 0. Then `sensor_raw` is held high 3 cycles and dropped → `sensor` stays 0.
- **Ack and collision.** With `walk_req` = 1, pulse `walk_ack` → `walk_req` = 0 the next cycle. Release and re-press the button timed so the accept edge coincides with a `walk_ack` pulse → `walk_req` remains 1.
- **Held button and sensor level.** Hold `walk_raw` = 1 for 50 cycles → exactly one `walk_press`. Drive `sensor_raw` with a 1→0→1 pattern, each level held 8 cycles → `sensor` follows with a 5-cycle lag.
